pipe_ctrl: RTL and testbench

//   Pipeline controller for the 5-stage RV32I core; sequences IF/DEC/EX/MEM/WB register enables and flushes.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/pipe_ctrl_if.sv | 46 ++++
 rtl/pipe_ctrl_hazard_detect.sv | 42 ++++
 rtl/pipe_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - state encodings, forwarding selects and register-match helpers for pipe_ctrl
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_HALT     = 2'b10
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXM = 2'b01;
  localparam logic [1:0] FWD_MWB = 2'b10;

  // x0 is hardwired to zero, so a write to it never creates a dependency
  function automatic logic src_hit(input logic [4:0] rs, input logic [4:0] rd, input logic we);
    return we && (rd != 5'd0) && (rs == rd);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - pipeline-to-controller signal bundle; master is the datapath, slave is pipe_ctrl
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       dec_rs1;
  logic [4:0]       dec_rs2;
  logic             dec_use1;
  logic             dec_use2;
  logic [4:0]       ex_rd;
  logic             ex_we;
  logic             ex_load;
  logic [4:0]       mem_rd;
  logic             mem_we;
  logic             branch_taken;
  logic             halt_ex;
  logic             resume;
  logic             dmem_req;
  logic             dmem_ack;
  logic             pc_en;
  logic             ifd_en;
  logic             dex_en;
  logic             exm_en;
  logic             mwb_en;
  logic             ifd_flush;
  logic             dex_flush;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic [1:0]       state;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output dec_rs1, dec_rs2, dec_use1, dec_use2, ex_rd, ex_we, ex_load, mem_rd, mem_we,
           branch_taken, halt_ex, resume, dmem_req, dmem_ack,
    input  pc_en, ifd_en, dex_en, exm_en, mwb_en, ifd_flush, dex_flush,
           fwd_a_sel, fwd_b_sel, state, mem_err, stall_cnt
  );

  modport slave (
    input  dec_rs1, dec_rs2, dec_use1, dec_use2, ex_rd, ex_we, ex_load, mem_rd, mem_we,
           branch_taken, halt_ex, resume, dmem_req, dmem_ack,
    output pc_en, ifd_en, dex_en, exm_en, mwb_en, ifd_flush, dex_flush,
           fwd_a_sel, fwd_b_sel, state, mem_err, stall_cnt
  );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// rtl/pipe_ctrl_hazard_detect.sv - combinational rs/rd compare: load-use, RAW stall, next forwarding selects
// FORWARDING_EN defined: forward from EX/MEM and MEM/WB; undefined: stall on any EX/MEM dependency.
module pipe_ctrl_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] dec_rs1,
  input  logic [4:0] dec_rs2,
  input  logic       dec_use1,
  input  logic       dec_use2,
  input  logic [4:0] ex_rd,
  input  logic       ex_we,
  input  logic       ex_load,
  input  logic [4:0] mem_rd,
  input  logic       mem_we,
  output logic       load_use,
  output logic       raw_stall,
  output logic [1:0] fwd_a_nxt,
  output logic [1:0] fwd_b_nxt
);

  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;

  assign ex_hit1  = src_hit(dec_rs1, ex_rd, ex_we);
  assign ex_hit2  = src_hit(dec_rs2, ex_rd, ex_we);
  assign mem_hit1 = src_hit(dec_rs1, mem_rd, mem_we);
  assign mem_hit2 = src_hit(dec_rs2, mem_rd, mem_we);

  assign load_use = ex_load && ((dec_use1 && ex_hit1) || (dec_use2 && ex_hit2));

`ifdef FORWARDING_EN
  assign raw_stall = 1'b0;
  // the younger producer in EX holds the newer value, so it beats MEM
  assign fwd_a_nxt = ex_hit1 ? FWD_EXM : (mem_hit1 ? FWD_MWB : FWD_RF);
  assign fwd_b_nxt = ex_hit2 ? FWD_EXM : (mem_hit2 ? FWD_MWB : FWD_RF);
`else
  // WB needs no check: the register file writes before it is read
  assign raw_stall = (dec_use1 && (ex_hit1 || mem_hit1)) || (dec_use2 && (ex_hit2 || mem_hit2));
  assign fwd_a_nxt = FWD_RF;
  assign fwd_b_nxt = FWD_RF;
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - 5-stage RV32I pipeline controller: enables, flushes, forwarding, dmem timeout, halt
// Optional forwarding selected by the FORWARDING_EN macro (see pipe_ctrl_hazard_detect).
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  localparam int TW = $clog2(MEM_TIMEOUT);

  state_t           st_q, st_d;
  logic [TW-1:0]    timer_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       fwd_a_q, fwd_b_q;
  logic             load_use, raw_stall;
  logic [1:0]       fwd_a_nxt, fwd_b_nxt;
  logic             mem_stall, flow, timeout;
  logic             pc_en, ifd_en, dex_en, exm_en, mwb_en, ifd_flush, dex_flush;

  pipe_ctrl_hazard_detect u_hazard (
    .dec_rs1   (bus.dec_rs1),
    .dec_rs2   (bus.dec_rs2),
    .dec_use1  (bus.dec_use1),
    .dec_use2  (bus.dec_use2),
    .ex_rd     (bus.ex_rd),
    .ex_we     (bus.ex_we),
    .ex_load   (bus.ex_load),
    .mem_rd    (bus.mem_rd),
    .mem_we    (bus.mem_we),
    .load_use  (load_use),
    .raw_stall (raw_stall),
    .fwd_a_nxt (fwd_a_nxt),
    .fwd_b_nxt (fwd_b_nxt)
  );

  assign mem_stall = (st_q == ST_RUN) && bus.dmem_req && !bus.dmem_ack;
  // flow: the pipeline may move this cycle, subject to halt/branch/hazard decode
  assign flow      = ((st_q == ST_RUN) && !mem_stall) || ((st_q == ST_MEM_WAIT) && bus.dmem_ack);
  assign timeout   = (timer_q == TW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) st_q <= ST_RUN;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_RUN: begin
        if (mem_stall)        st_d = ST_MEM_WAIT;
        else if (bus.halt_ex) st_d = ST_HALT;
      end
      ST_MEM_WAIT: begin
        if (bus.dmem_ack)     st_d = bus.halt_ex ? ST_HALT : ST_RUN;
        else if (timeout)     st_d = ST_HALT;
      end
      ST_HALT: begin
        if (bus.resume)       st_d = ST_RUN;
      end
      default:                st_d = ST_RUN;
    endcase
  end

  always_comb begin
    {pc_en, ifd_en, dex_en, exm_en, mwb_en} = 5'b00000;
    ifd_flush = 1'b0;
    dex_flush = 1'b0;
    if (rst) begin
      ifd_flush = 1'b1;
      dex_flush = 1'b1;
    end else if (flow) begin
      if (bus.halt_ex) begin
        // let the ECALL/EBREAK and older work drain, freeze everything younger
        {exm_en, mwb_en} = 2'b11;
      end else if (bus.branch_taken) begin
        {pc_en, ifd_en, dex_en, exm_en, mwb_en} = 5'b11111;
        ifd_flush = 1'b1;
        dex_flush = 1'b1;
      end else if (load_use || raw_stall) begin
        {dex_en, exm_en, mwb_en} = 3'b111;
        dex_flush = 1'b1;
      end else begin
        {pc_en, ifd_en, dex_en, exm_en, mwb_en} = 5'b11111;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || st_q != ST_MEM_WAIT || bus.dmem_ack || timeout) timer_q <= '0;
    else                                                        timer_q <= timer_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                                                    err_q <= 1'b0;
    else if (st_q == ST_MEM_WAIT && !bus.dmem_ack && timeout)   err_q <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                                                    cnt_q <= '0;
    else if (!pc_en && st_q != ST_HALT && cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
  end

  // selects follow the instruction into DEC/EX, so they move only with dex_en
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (dex_en) begin
      fwd_a_q <= dex_flush ? FWD_RF : fwd_a_nxt;
      fwd_b_q <= dex_flush ? FWD_RF : fwd_b_nxt;
    end
  end

  assign bus.pc_en     = pc_en;
  assign bus.ifd_en    = ifd_en;
  assign bus.dex_en    = dex_en;
  assign bus.exm_en    = exm_en;
  assign bus.mwb_en    = mwb_en;
  assign bus.ifd_flush = ifd_flush;
  assign bus.dex_flush = dex_flush;
  assign bus.fwd_a_sel = fwd_a_q;
  assign bus.fwd_b_sel = fwd_b_q;
  assign bus.state     = st_q;
  assign bus.mem_err   = err_q;
  assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed scoreboard bench for pipe_ctrl (expectations follow FORWARDING_EN)
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int          CW      = 5;
  localparam int          TMO     = 16;
  localparam logic [31:0] CNT_MAX = (32'd1 << CW) - 32'd1;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [4:0] EN_ALL  = 5'b11111;
  localparam logic [4:0] EN_NONE = 5'b00000;
  localparam logic [4:0] EN_BUB  = 5'b00111;
  localparam logic [4:0] EN_HALT = 5'b00011;

  typedef struct {
    string       tag;
    logic [4:0]  en;
    logic [1:0]  fl;
    logic [1:0]  st;
    logic [3:0]  fwd;
    logic [31:0] cnt;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] model_cnt = 32'd0;

  pipe_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.dec_rs1 = 5'd0; bus.dec_rs2 = 5'd0; bus.dec_use1 = 1'b0; bus.dec_use2 = 1'b0;
    bus.ex_rd = 5'd0; bus.ex_we = 1'b0; bus.ex_load = 1'b0;
    bus.mem_rd = 5'd0; bus.mem_we = 1'b0;
    bus.branch_taken = 1'b0; bus.halt_ex = 1'b0; bus.resume = 1'b0;
    bus.dmem_req = 1'b0; bus.dmem_ack = 1'b0;
  endtask

  task automatic step(input string tag, input logic [4:0] en, input logic [1:0] fl,
                      input logic [1:0] st, input logic [1:0] fa, input logic [1:0] fb,
                      input logic err);
    exp_t e;
    e.tag = tag; e.en = en; e.fl = fl; e.st = st; e.fwd = {fa, fb}; e.cnt = model_cnt; e.err = err;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk({e.tag, ".en"},    32'({bus.pc_en, bus.ifd_en, bus.dex_en, bus.exm_en, bus.mwb_en}), 32'(e.en));
    chk({e.tag, ".flush"}, 32'({bus.ifd_flush, bus.dex_flush}), 32'(e.fl));
    chk({e.tag, ".state"}, 32'(bus.state), 32'(e.st));
    chk({e.tag, ".fwd"},   32'({bus.fwd_a_sel, bus.fwd_b_sel}), 32'(e.fwd));
    chk({e.tag, ".cnt"},   32'(bus.stall_cnt), e.cnt);
    chk({e.tag, ".err"},   32'(bus.mem_err), 32'(e.err));
    if (rst) model_cnt = 32'd0;
    else if (!e.en[4] && e.st != ST_HALT && model_cnt != CNT_MAX) model_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_load_use();
    bus.dec_rs1 = 5'd5; bus.dec_use1 = 1'b1; bus.dec_rs2 = 5'd9; bus.dec_use2 = 1'b1;
    bus.ex_rd = 5'd5; bus.ex_we = 1'b1; bus.ex_load = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    @(posedge clk);
    #1;
    repeat (3) step("reset", EN_NONE, 2'b11, ST_RUN, FWD_RF, FWD_RF, 1'b0);
    rst = 1'b0;
    step("run", EN_ALL, 2'b00, ST_RUN, FWD_RF, FWD_RF, 1'b0);
    bus.resume = 1'b1;
    step("resume_in_run", EN_ALL, 2'b00, ST_RUN, FWD_RF, FWD_RF, 1'b0);
    clr();
    step("resume_ignored", EN_ALL, 2'b00, ST_RUN, FWD_RF, FWD_RF, 1'b0);

    clr(); set_load_use();
    step("lu_stall", EN_BUB, 2'b01, ST_RUN, FWD_RF, FWD_RF, 1'b0);
    clr(); bus.dec_rs1 = 5'd5; bus.dec_use1 = 1'b1; bus.mem_rd = 5'd5; bus.mem_we = 1'b1;
    step("lu_after", FWD ? EN_ALL : EN_BUB, FWD ? 2'b00 : 2'b01, ST_RUN, FWD_RF, FWD_RF, 1'b0);
    clr();
    step("lu_fwd", EN_ALL, 2'b00, ST_RUN, FWD ? FWD_MWB : FWD_RF, FWD_RF, 1'b0);

`ifdef FORWARDING_EN
    clr(); bus.dec_rs2 = 5'd3; bus.dec_use2 = 1'b1; bus.ex_rd = 5'd3; bus.ex_we = 1'b1;
    bus.dec_rs1 = 5'd4; bus.dec_use1 = 1'b1; bus.mem_rd = 5'd4; bus.mem_we = 1'b1;
    step("raw_nostall", EN_ALL, 2'b00, ST_RUN, FWD_RF, FWD_RF, 1'b0);
    clr(); bus.dec_rs1 = 5'd7; bus.dec_use1 = 1'b1; bus.ex_rd = 5'd7; bus.ex_we = 1'b1;
    bus.mem_rd = 5'd7; bus.mem_we = 1'b1;
    step("raw_fwd", EN_ALL, 2'b00, ST_RUN, FWD_MWB, FWD_EXM, 1'b0);
    clr(); bus.dec_rs1 = 5'd6; bus.ex_rd = 5'd6;
    step("ex_wins", EN_ALL, 2'b00, ST_RUN, FWD_EXM, FWD_RF, 1'b0);
`else
    clr(); bus.dec_rs2 = 5'd3; bus.dec_use2 = 1'b1; bus.ex_rd = 5'd3; bus.ex_we = 1'b1;
    step("raw_stall_ex", EN_BUB, 2'b01, ST_RUN, FWD_RF, FWD_RF, 1'b0);
    clr(); bus.dec_rs2 = 5'd3; bus.dec_use2 = 1'b1; bus.mem_rd = 5'd3; bus.mem_we = 1'b1;
    step("raw_stall_mem", EN_BUB, 2'b01, ST_RUN, FWD_RF, FWD_RF, 1'b0);
    clr(); bus.dec_rs2 = 5'd3; bus.dec_use2 = 1'b1;
    step("raw_clear", EN_ALL, 2'b00, ST_RUN, FWD_RF, FWD_RF, 1'b0);
    clr(); bus.dec_rs1 = 5'd8; bus.ex_rd = 5'd8; bus.ex_we = 1'b1;
    step("raw_nouse", EN_ALL, 2'b00, ST_RUN, FWD_RF, FWD_RF, 1'b0);
`endif

    clr(); bus.dec_use1 = 1'b1; bus.dec_use2 = 1'b1; bus.ex_we = 1'b1; bus.ex_load = 1'b1;
    bus.mem_we = 1'b1;
    step("x0", EN_ALL, 2'b00, ST_RUN, FWD_RF, FWD_RF, 1'b0);
    clr();
    step("x0_nofwd", EN_ALL, 2'b00, ST_RUN, FWD_RF, FWD_RF, 1'b0);

    clr(); set_load_use(); bus.branch_taken = 1'b1;
    step("br_lu", EN_ALL, 2'b11, ST_RUN, FWD_RF, FWD_RF, 1'b0);
    clr();
    step("br_after", EN_ALL, 2'b00, ST_RUN, FWD_RF, FWD_RF, 1'b0);

    clr(); bus.dec_rs1 = 5'd2; bus.ex_rd = 5'd2; bus.ex_we = 1'b1;
    step("pre_mem", EN_ALL, 2'b00, ST_RUN, FWD_RF, FWD_RF, 1'b0);
    clr(); bus.dmem_req = 1'b1;
    step("mem_stall", EN_NONE, 2'b00, ST_RUN, FWD ? FWD_EXM : FWD_RF, FWD_RF, 1'b0);
    for (int i = 0; i < 3; i++)
      step("mem_wait", EN_NONE, 2'b00, ST_MEM_WAIT, FWD ? FWD_EXM : FWD_RF, FWD_RF, 1'b0);
    bus.dmem_ack = 1'b1;
    step("mem_ack", EN_ALL, 2'b00, ST_MEM_WAIT, FWD ? FWD_EXM : FWD_RF, FWD_RF, 1'b0);
    clr();
    step("mem_done", EN_ALL, 2'b00, ST_RUN, FWD_RF, FWD_RF, 1'b0);
    bus.dmem_req = 1'b1; bus.dmem_ack = 1'b1;
    step("ack_same", EN_ALL, 2'b00, ST_RUN, FWD_RF, FWD_RF, 1'b0);
    clr();
    step("ack_same_next", EN_ALL, 2'b00, ST_RUN, FWD_RF, FWD_RF, 1'b0);

    bus.dmem_req = 1'b1;
    step("tmo_start", EN_NONE, 2'b00, ST_RUN, FWD_RF, FWD_RF, 1'b0);
    for (int i = 0; i < TMO; i++)
      step("tmo_wait", EN_NONE, 2'b00, ST_MEM_WAIT, FWD_RF, FWD_RF, 1'b0);
    clr();
    step("tmo_halt", EN_NONE, 2'b00, ST_HALT, FWD_RF, FWD_RF, 1'b1);
    bus.resume = 1'b1;
    step("tmo_resume", EN_NONE, 2'b00, ST_HALT, FWD_RF, FWD_RF, 1'b1);
    clr();
    step("tmo_run", EN_ALL, 2'b00, ST_RUN, FWD_RF, FWD_RF, 1'b1);

    bus.halt_ex = 1'b1;
    step("halt_ex", EN_HALT, 2'b00, ST_RUN, FWD_RF, FWD_RF, 1'b1);
    bus.dmem_req = 1'b1;
    for (int i = 0; i < 10; i++)
      step("halt_hold", EN_NONE, 2'b00, ST_HALT, FWD_RF, FWD_RF, 1'b1);
    clr(); bus.resume = 1'b1;
    step("halt_resume", EN_NONE, 2'b00, ST_HALT, FWD_RF, FWD_RF, 1'b1);
    clr();
    step("halt_run", EN_ALL, 2'b00, ST_RUN, FWD_RF, FWD_RF, 1'b1);

    set_load_use();
    for (int i = 0; i < 40; i++)
      step("sat", EN_BUB, 2'b01, ST_RUN, FWD_RF, FWD_RF, 1'b1);
    clr();
    step("sat_hold", EN_ALL, 2'b00, ST_RUN, FWD_RF, FWD_RF, 1'b1);

    rst = 1'b1;
    step("rst_again", EN_NONE, 2'b11, ST_RUN, FWD_RF, FWD_RF, 1'b1);
    step("rst_clear", EN_NONE, 2'b11, ST_RUN, FWD_RF, FWD_RF, 1'b0);
    rst = 1'b0;
    step("post_rst", EN_ALL, 2'b00, ST_RUN, FWD_RF, FWD_RF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
